// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard/forwarding controller: operand-select
// encoding, per-stage destination tracking entry, and the hardwired-zero register index.
package hazard_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_ALT   = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 wr;
    logic                 load;
  } dest_entry_t;

endpackage

// File: rtl/hazard_dest_stage.sv
// One pipeline-stage destination tracker; bubble or reset clears only the valid bit,
// the payload fields simply follow the upstream entry.
module hazard_dest_stage
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble,
  input  dest_entry_t d,
  output dest_entry_t q
);

  always_ff @(posedge clk) begin
    q.rd   <= d.rd;
    q.wr   <= d.wr;
    q.load <= d.load;
    if (reset || bubble) begin
      q.valid <= 1'b0;
    end else begin
      q.valid <= d.valid;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Decode-stage hazard/forwarding controller: registered EX operand selects, load-use stall.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_IDX_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  id_a_is_pc,
  input  logic                  id_b_is_imm,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  ex_flush,
  output logic                  stall,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic [31:0]           perf_stalls,
  output logic [31:0]           perf_fwds
);

  dest_entry_t id_ent, ex_ent_p0, mem_ent_p1, wb_ent_p2;
  fwd_sel_e    sel_a, sel_b, sel_a_p0, sel_b_p0;
  logic        a_hit_ex, a_hit_mem, b_hit_ex, b_hit_mem;
  logic        adv;
  logic        unused_p2;

  function automatic logic match(input logic used, input logic [REG_ADDR_W-1:0] x,
                                 input dest_entry_t s);
    return used && (x != REG_ZERO) && s.valid && s.wr && (s.rd == x);
  endfunction

  // Youngest producer wins; WB producers are covered by regfile write-through.
  function automatic fwd_sel_e pick_sel(input logic alt, input logic hit_ex, input logic hit_mem);
    if (alt)     return FWD_ALT;
    if (hit_ex)  return FWD_EXMEM;
    if (hit_mem) return FWD_MEMWB;
    return FWD_RF;
  endfunction

  assign id_ent = '{valid: id_valid, rd: id_rd, wr: id_reg_write, load: id_is_load};

  assign a_hit_ex  = match(id_rs1_used, id_rs1, ex_ent_p0);
  assign a_hit_mem = match(id_rs1_used, id_rs1, mem_ent_p1);
  assign b_hit_ex  = match(id_rs2_used, id_rs2, ex_ent_p0);
  assign b_hit_mem = match(id_rs2_used, id_rs2, mem_ent_p1);

  assign sel_a = pick_sel(id_a_is_pc,  a_hit_ex, a_hit_mem);
  assign sel_b = pick_sel(id_b_is_imm, b_hit_ex, b_hit_mem);

  assign stall = id_valid && !ex_flush && !reset && ex_ent_p0.valid && ex_ent_p0.load
                 && (a_hit_ex || b_hit_ex);
  assign adv   = id_valid && !stall && !ex_flush;

  // ---- ID -> EX (p0) ----
  hazard_dest_stage u_ex (
    .clk(clk), .reset(reset), .bubble(!adv), .d(id_ent), .q(ex_ent_p0)
  );

  always_ff @(posedge clk) begin
    if (reset || !adv) begin
      sel_a_p0 <= FWD_RF;
      sel_b_p0 <= FWD_RF;
    end else begin
      sel_a_p0 <= sel_a;
      sel_b_p0 <= sel_b;
    end
  end

  assign fwd_sel_a = sel_a_p0;
  assign fwd_sel_b = sel_b_p0;

  // ---- EX -> MEM (p1) ----
  hazard_dest_stage u_mem (
    .clk(clk), .reset(reset), .bubble(1'b0), .d(ex_ent_p0), .q(mem_ent_p1)
  );

  // ---- MEM -> WB (p2) ----
  hazard_dest_stage u_wb (
    .clk(clk), .reset(reset), .bubble(1'b0), .d(mem_ent_p1), .q(wb_ent_p2)
  );

  assign unused_p2 = ^{mem_ent_p1.load, wb_ent_p2};

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, fwd_cnt;
  logic [1:0]  fwd_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, acc} + {31'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  function automatic logic is_fwd(input fwd_sel_e s);
    return (s == FWD_EXMEM) || (s == FWD_MEMWB);
  endfunction

  assign fwd_inc = adv ? ({1'b0, is_fwd(sel_a)} + {1'b0, is_fwd(sel_b)}) : 2'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      stall_cnt <= sat_add(stall_cnt, {1'b0, stall});
      fwd_cnt   <= sat_add(fwd_cnt, fwd_inc);
    end
  end

  assign perf_stalls = stall_cnt;
  assign perf_fwds   = fwd_cnt;
`else
  assign perf_stalls = 32'h0;
  assign perf_fwds   = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed scenarios plus random traffic checked against
// a queue-based model of the in-flight instructions.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        reset, id_valid, id_rs1_used, id_rs2_used, id_a_is_pc, id_b_is_imm;
  logic        id_reg_write, id_is_load, ex_flush;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        stall;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [31:0] perf_stalls, perf_fwds;

  always #5 clk = ~clk;

  hazard_forward_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_a_is_pc(id_a_is_pc),
    .id_b_is_imm(id_b_is_imm), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .ex_flush(ex_flush), .stall(stall), .fwd_sel_a(fwd_sel_a),
    .fwd_sel_b(fwd_sel_b), .perf_stalls(perf_stalls), .perf_fwds(perf_fwds)
  );

  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } ins_t;

  ins_t   pipe[$];   // [0]=EX, [1]=MEM, [2]=WB
  int     total = 0;
  int     bad = 0;
  int     exp_a = 0, exp_b = 0;
  longint exp_ps = 0, exp_pf = 0;
  logic   obs_stall;
  logic [31:0] ps_before;

  function automatic bit hit(bit used, int r, ins_t s);
    return used && (r != 0) && s.v && s.wr && (s.rd == r);
  endfunction

  function automatic int pick(bit alt, bit used, int r);
    if (alt) return 3;
    if (hit(used, r, pipe[0])) return 1;
    if (hit(used, r, pipe[1])) return 2;
    return 0;
  endfunction

  task automatic clear_pipe();
    pipe.delete();
    repeat (3) pipe.push_back(ins_t'{1'b0, 0, 1'b0, 1'b0});
  endtask

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic setid(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                       input bit apc, input bit bimm, input int rd, input bit wr, input bit ld,
                       input bit fl, input bit rs);
    id_valid = v; id_rs1 = 5'(r1); id_rs1_used = u1; id_rs2 = 5'(r2); id_rs2_used = u2;
    id_a_is_pc = apc; id_b_is_imm = bimm; id_rd = 5'(rd); id_reg_write = wr;
    id_is_load = ld; ex_flush = fl; reset = rs;
  endtask

  task automatic tick(input string tag);
    bit es, adv;
    int sa, sb;
    #3;
    es = id_valid && !ex_flush && !reset && pipe[0].v && pipe[0].ld &&
         (hit(id_rs1_used, int'(id_rs1), pipe[0]) || hit(id_rs2_used, int'(id_rs2), pipe[0]));
    obs_stall = stall;
    chk({tag, ".stall"}, {33'b0, stall}, {33'b0, es});
    sa  = pick(id_a_is_pc,  id_rs1_used, int'(id_rs1));
    sb  = pick(id_b_is_imm, id_rs2_used, int'(id_rs2));
    adv = id_valid && !es && !ex_flush;
    @(posedge clk);
    if (reset) begin
      clear_pipe();
      exp_a = 0; exp_b = 0; exp_ps = 0; exp_pf = 0;
    end else begin
      pipe.push_front(adv ? ins_t'{1'b1, int'(id_rd), id_reg_write, id_is_load}
                          : ins_t'{1'b0, 0, 1'b0, 1'b0});
      void'(pipe.pop_back());
      exp_a = adv ? sa : 0;
      exp_b = adv ? sb : 0;
      if (es) exp_ps++;
      if (adv) exp_pf += ((sa == 1 || sa == 2) ? 1 : 0) + ((sb == 1 || sb == 2) ? 1 : 0);
    end
    #1;
    chk({tag, ".sel_a"}, {32'b0, fwd_sel_a}, 34'(exp_a));
    chk({tag, ".sel_b"}, {32'b0, fwd_sel_b}, 34'(exp_b));
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, ".perf_stalls"}, {2'b0, perf_stalls}, 34'(exp_ps));
    chk({tag, ".perf_fwds"},   {2'b0, perf_fwds},   34'(exp_pf));
`else
    chk({tag, ".perf_stalls"}, {2'b0, perf_stalls}, 34'd0);
    chk({tag, ".perf_fwds"},   {2'b0, perf_fwds},   34'd0);
`endif
  endtask

  initial begin
    clear_pipe();
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick("rst0");
    tick("rst1");
    chk("rst.sel_a", {32'b0, fwd_sel_a}, 34'd0);
    chk("rst.stall", {33'b0, obs_stall}, 34'd0);

    // add x5 in EX, decode reads x5 on rs1
    setid(1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0); tick("t1a");
    setid(1, 5, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0); tick("t1b");
    chk("t1.fwd_a", {32'b0, fwd_sel_a}, 34'd1);
    chk("t1.nostall", {33'b0, obs_stall}, 34'd0);

    // add x5 in MEM only, then EX and MEM both writing x5
    setid(1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0); tick("t2a");
    setid(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick("t2b");
    setid(1, 0, 0, 5, 1, 0, 0, 3, 0, 0, 0, 0); tick("t2c");
    chk("t2.fwd_b_mem", {32'b0, fwd_sel_b}, 34'd2);
    setid(1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0); tick("t2d");
    setid(1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0); tick("t2e");
    setid(1, 0, 0, 5, 1, 0, 0, 3, 0, 0, 0, 0); tick("t2f");
    chk("t2.fwd_b_ex", {32'b0, fwd_sel_b}, 34'd1);

    // load-use: one stall cycle, bubble, then MEM/WB forward
    setid(1, 0, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0); tick("t3a");
    setid(1, 7, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0); tick("t3b");
    chk("t3.stall", {33'b0, obs_stall}, 34'd1);
    chk("t3.bubble_a", {32'b0, fwd_sel_a}, 34'd0);
    tick("t3c");
    chk("t3.unstall", {33'b0, obs_stall}, 34'd0);
    chk("t3.fwd_a_mem", {32'b0, fwd_sel_a}, 34'd2);

    // flush overrides load-use stall
    setid(1, 0, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0); tick("t4a");
    ps_before = perf_stalls;
    setid(1, 7, 1, 0, 0, 0, 0, 8, 1, 0, 1, 0); tick("t4b");
    chk("t4.nostall", {33'b0, obs_stall}, 34'd0);
    chk("t4.bubble_a", {32'b0, fwd_sel_a}, 34'd0);
    chk("t4.no_count", {2'b0, perf_stalls}, {2'b0, ps_before});

    // x0 never forwarded; immediate overrides a real match
    setid(1, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0); tick("t5a");
    setid(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); tick("t5b");
    setid(1, 0, 1, 4, 1, 0, 1, 2, 0, 0, 0, 0); tick("t5c");
    chk("t5.x0_a", {32'b0, fwd_sel_a}, 34'd0);
    chk("t5.imm_b", {32'b0, fwd_sel_b}, 34'd3);

    // reset in the middle of a load-use stall
    setid(1, 0, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0); tick("t6a");
    setid(1, 7, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0); tick("t6b");
    chk("t6.stall", {33'b0, obs_stall}, 34'd1);
    setid(1, 7, 1, 0, 0, 0, 0, 8, 1, 0, 0, 1); tick("t6c");
    setid(1, 7, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0); tick("t6d");
    chk("t6.post_rst_stall", {33'b0, obs_stall}, 34'd0);
    chk("t6.post_rst_a", {32'b0, fwd_sel_a}, 34'd0);
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick("t6e");
    for (int i = 0; i < 3; i++) begin
      setid(1, 0, 0, 0, 0, 0, 0, 6, 1, 1, 0, 0); tick("t6ld");
      setid(1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0); tick("t6use");
      tick("t6res");
    end
`ifdef HAZARD_PERF_CNT_EN
    chk("t6.perf3", {2'b0, perf_stalls}, 34'd3);
`else
    chk("t6.perf_off", {2'b0, perf_stalls}, 34'd0);
`endif

    // random traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      setid(($urandom_range(9, 0) < 8), $urandom_range(3, 0), $urandom_range(1, 0),
            $urandom_range(3, 0), $urandom_range(1, 0), ($urandom_range(9, 0) == 0),
            ($urandom_range(9, 0) == 0), $urandom_range(3, 0), ($urandom_range(9, 0) < 7),
            ($urandom_range(9, 0) < 3), ($urandom_range(9, 0) == 0),
            ($urandom_range(49, 0) == 0));
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
